spi_count_receiver: RTL and testbench

SPI_COUNT_RECEIVER -- requirements
Module: spi_count_receiver

---
 rtl/counter_pkg.sv | 16 +
 rtl/sync_edge_det.sv | 34 +++
 rtl/spi_count_receiver.sv | 143 ++++++++++++++
 tb/tb_spi_count_receiver.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and defaults for the count receiver, the counter and the SPI master.
// The frame is two reserved bits followed by a COUNT_W-bit count, MSB first.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int COUNT_W            = 14;
    localparam int FRAME_W            = COUNT_W + 2;
    localparam int DEFAULT_FRAME_BITS = 16;
    localparam int DEFAULT_MAX_COUNT  = 10000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input, plus one-cycle rise/fall
// pulses derived from the synchronized value and its previous sample.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
            prev_p2 <= RST_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign q    = sync_p1;
    assign rise = sync_p1 & ~prev_p2;
    assign fall = ~sync_p1 & prev_p2;

endmodule

// File: rtl/spi_count_receiver.sv
// SPI mode-0 slave that receives a framed count value, validates it, and
// returns the last accepted frame on miso during the following transfer.
module spi_count_receiver
    import counter_pkg::*;
#(
    parameter int MAX_COUNT  = DEFAULT_MAX_COUNT,
    parameter int FRAME_BITS = DEFAULT_FRAME_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk,
    input  logic               mosi,
    input  logic               cs_n,
    output logic               miso,
    output logic [COUNT_W-1:0] count_data,
    output logic               data_valid,
    output logic               frame_err
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    state_t state_q;
    state_t state_d;

    logic sclk_q, sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall;
    logic mosi_p0, mosi_p1;

    logic [1:0]         settle_cnt;
    logic               cs_armed;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] rx_sr;
    logic [FRAME_W-1:0] miso_sr;

    logic start;
    logic accept;

    sync_edge_det #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sclk),
        .q    (sclk_q),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    sync_edge_det #(.RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (cs_n),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // mosi has the same depth as the sclk chain, so mosi_p1 lines up with sclk_rise
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    // A cs_n that is already low when reset releases must not open a frame:
    // only arm once the refilled synchronizer has actually shown cs_n high.
    assign start  = cs_fall & cs_armed;
    assign accept = (bit_cnt == CNT_FULL) &&
                    (rx_sr[FRAME_W-1:COUNT_W] == 2'b00) &&
                    (32'(rx_sr[COUNT_W-1:0]) < MAX_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= 2'd0;
            cs_armed   <= 1'b0;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            miso_sr    <= '0;
            count_data <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (settle_cnt != 2'd2) settle_cnt <= settle_cnt + 2'd1;
            if (settle_cnt == 2'd2 && cs_q) cs_armed <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        bit_cnt <= '0;
                        rx_sr   <= '0;
                        miso_sr <= {2'b00, count_data};
                    end
                end
                SHIFT: begin
                    // an sclk rise landing with the cs_n rise belongs to no frame
                    if (!cs_rise) begin
                        if (sclk_rise) begin
                            rx_sr <= {rx_sr[FRAME_W-2:0], mosi_p1};
                            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (sclk_fall) miso_sr <= {miso_sr[FRAME_W-2:0], 1'b0};
                    end
                end
                CHECK: begin
                    if (accept) begin
                        count_data <= rx_sr[COUNT_W-1:0];
                        data_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign miso = ~cs_q & miso_sr[FRAME_W-1];

endmodule

// File: tb/tb_spi_count_receiver.sv
// Directed bench: an SPI mode-0 master task drives frames and the resulting
// pulses, count_data and returned miso word are compared against fixed values.
module tb_spi_count_receiver;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic        miso;
    logic [13:0] count_data;
    logic        data_valid;
    logic        frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int dv_total = 0;
    int fe_total = 0;
    int both_total = 0;
    int dv0, fe0;
    logic [15:0] rx_word;

    spi_count_receiver #(.MAX_COUNT(10000), .FRAME_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .miso       (miso),
        .count_data (count_data),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) dv_total++;
        if (frame_err) fe_total++;
        if (data_valid && frame_err) both_total++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    task automatic send_frame(input logic [31:0] val, input int nbits, input bit raise_cs,
                              output logic [15:0] miso_word);
        miso_word = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = val[nbits-1-i];
            repeat (HALF) @(negedge clk);
            miso_word = {miso_word[14:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        if (raise_cs) begin
            cs_n = 1'b1;
            repeat (3 * HALF) @(negedge clk);
        end
    endtask

    task automatic snap();
        dv0 = dv_total;
        fe0 = fe_total;
    endtask

    initial begin
        rst  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_count", 32'(count_data), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_err",   32'(frame_err),  32'd0);
        check("rst_miso",  32'(miso),       32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        snap();
        send_frame(32'h1234, 16, 1'b1, rx_word);
        check("f1234_count", 32'(count_data), 32'd4660);
        check("f1234_valid", dv_total - dv0, 32'd1);
        check("f1234_err",   fe_total - fe0, 32'd0);

        snap();
        send_frame(32'h270F, 16, 1'b1, rx_word);
        check("f270f_count", 32'(count_data), 32'd9999);
        check("f270f_valid", dv_total - dv0, 32'd1);
        check("f270f_err",   fe_total - fe0, 32'd0);

        snap();
        send_frame(32'h2710, 16, 1'b1, rx_word);
        check("f2710_count", 32'(count_data), 32'd9999);
        check("f2710_valid", dv_total - dv0, 32'd0);
        check("f2710_err",   fe_total - fe0, 32'd1);

        snap();
        send_frame(32'h4001, 16, 1'b1, rx_word);
        check("f4001_count", 32'(count_data), 32'd9999);
        check("f4001_valid", dv_total - dv0, 32'd0);
        check("f4001_err",   fe_total - fe0, 32'd1);

        snap();
        send_frame(32'h0123, 15, 1'b1, rx_word);
        check("len15_count", 32'(count_data), 32'd9999);
        check("len15_err",   fe_total - fe0, 32'd1);
        check("len15_valid", dv_total - dv0, 32'd0);

        snap();
        send_frame(32'h00123, 17, 1'b1, rx_word);
        check("len17_count", 32'(count_data), 32'd9999);
        check("len17_err",   fe_total - fe0, 32'd1);
        check("len17_valid", dv_total - dv0, 32'd0);

        send_frame(32'h0005, 16, 1'b1, rx_word);
        check("f0005_count", 32'(count_data), 32'd5);
        snap();
        send_frame(32'h0100, 16, 1'b1, rx_word);
        check("miso_word",   32'(rx_word),    32'h0005);
        check("f0100_count", 32'(count_data), 32'd256);
        check("f0100_valid", dv_total - dv0,  32'd1);

        // reset in the middle of a frame while cs_n stays low
        snap();
        send_frame(32'h12, 8, 1'b0, rx_word);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_frame(32'h34, 8, 1'b1, rx_word);
        check("midrst_count", 32'(count_data), 32'd0);
        check("midrst_valid", dv_total - dv0,  32'd0);
        check("midrst_err",   fe_total - fe0,  32'd0);

        snap();
        send_frame(32'h0007, 16, 1'b1, rx_word);
        check("f0007_count", 32'(count_data), 32'd7);
        check("f0007_valid", dv_total - dv0,  32'd1);

        snap();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_err",   fe_total - fe0,  32'd1);
        check("glitch_valid", dv_total - dv0,  32'd0);
        check("glitch_count", 32'(count_data), 32'd7);

        check("pulse_overlap", 32'(both_total), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
